// File: rtl/mpu_load.sv
// Inbound matrix loader: takes a row-major element stream over valid/ready and
// issues one register-file write per element, tagged with its (i, j) location.
module mpu_load #(
   parameter int FP              = 64,
   parameter int MBITS           = 2,
   parameter int NBITS           = 2,
   parameter int MATRIX_REG_SIZE = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load_req_in,
   input  logic [MATRIX_REG_SIZE-1:0] load_addr_in,
   input  logic [MBITS:0]             mem_m_load_size_in,
   input  logic [NBITS:0]             mem_n_load_size_in,
   input  logic                       mem_load_en_in,
   input  logic [FP-1:0]              mem_load_element_in,
   output logic                       mem_load_ready_out,
   output logic                       reg_load_en_out,
   output logic [FP-1:0]              reg_element_out,
   output logic [MBITS:0]             reg_i_load_loc_out,
   output logic [NBITS:0]             reg_j_load_loc_out,
   output logic [MBITS:0]             reg_m_load_size_out,
   output logic [NBITS:0]             reg_n_load_size_out,
   output logic [MATRIX_REG_SIZE-1:0] reg_load_addr_out,
   output logic                       reg_load_complete_out,
   output logic                       load_busy_out,
   output logic                       load_error_out
);

   typedef enum logic {LOAD_IDLE, LOAD_MATRIX} state_t;

   localparam logic [MBITS:0] ROW_ONE = 1;
   localparam logic [NBITS:0] COL_ONE = 1;

   state_t                       state_q, state_d;
   logic [MBITS:0]               mSize_q, mSize_d;
   logic [NBITS:0]               nSize_q, nSize_d;
   logic [MATRIX_REG_SIZE-1:0]   addr_q, addr_d;
   logic [MBITS:0]               rowPtr_q, rowPtr_d;
   logic [NBITS:0]               colPtr_q, colPtr_d;
   logic                         regEn_q, regEn_d;
   logic [FP-1:0]                element_q, element_d;
   logic [MBITS:0]               iLoc_q, iLoc_d;
   logic [NBITS:0]               jLoc_q, jLoc_d;
   logic                         complete_q, complete_d;
   logic                         error_q, error_d;
   logic                         transfer;
   logic                         lastCol;
   logic                         lastElem;

   assign transfer = (state_q == LOAD_MATRIX) && mem_load_en_in;
   assign lastCol  = (colPtr_q == nSize_q - COL_ONE);
   assign lastElem = lastCol && (rowPtr_q == mSize_q - ROW_ONE);

   // Write-side registers hold their last values; only the strobes fall back to 0.
   always_comb begin
      state_d    = state_q;
      mSize_d    = mSize_q;
      nSize_d    = nSize_q;
      addr_d     = addr_q;
      rowPtr_d   = rowPtr_q;
      colPtr_d   = colPtr_q;
      regEn_d    = 1'b0;
      element_d  = element_q;
      iLoc_d     = iLoc_q;
      jLoc_d     = jLoc_q;
      complete_d = 1'b0;
      error_d    = 1'b0;
      case (state_q)
         LOAD_IDLE: begin
            if (load_req_in) begin
               if (mem_m_load_size_in == '0 || mem_n_load_size_in == '0) begin
                  error_d = 1'b1;
               end else begin
                  mSize_d  = mem_m_load_size_in;
                  nSize_d  = mem_n_load_size_in;
                  addr_d   = load_addr_in;
                  rowPtr_d = '0;
                  colPtr_d = '0;
                  state_d  = LOAD_MATRIX;
               end
            end
         end
         LOAD_MATRIX: begin
            if (transfer) begin
               regEn_d    = 1'b1;
               element_d  = mem_load_element_in;
               iLoc_d     = rowPtr_q;
               jLoc_d     = colPtr_q;
               complete_d = lastElem;
               if (lastCol) begin
                  colPtr_d = '0;
                  rowPtr_d = rowPtr_q + ROW_ONE;
               end else begin
                  colPtr_d = colPtr_q + COL_ONE;
               end
               if (lastElem) begin
                  state_d = LOAD_IDLE;
               end
            end
         end
         default: state_d = LOAD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= LOAD_IDLE;
         mSize_q    <= '0;
         nSize_q    <= '0;
         addr_q     <= '0;
         rowPtr_q   <= '0;
         colPtr_q   <= '0;
         regEn_q    <= 1'b0;
         element_q  <= '0;
         iLoc_q     <= '0;
         jLoc_q     <= '0;
         complete_q <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         mSize_q    <= mSize_d;
         nSize_q    <= nSize_d;
         addr_q     <= addr_d;
         rowPtr_q   <= rowPtr_d;
         colPtr_q   <= colPtr_d;
         regEn_q    <= regEn_d;
         element_q  <= element_d;
         iLoc_q     <= iLoc_d;
         jLoc_q     <= jLoc_d;
         complete_q <= complete_d;
         error_q    <= error_d;
      end
   end

   assign mem_load_ready_out    = (state_q == LOAD_MATRIX);
   assign load_busy_out         = (state_q == LOAD_MATRIX);
   assign reg_load_en_out       = regEn_q;
   assign reg_element_out       = element_q;
   assign reg_i_load_loc_out    = iLoc_q;
   assign reg_j_load_loc_out    = jLoc_q;
   assign reg_m_load_size_out   = mSize_q;
   assign reg_n_load_size_out   = nSize_q;
   assign reg_load_addr_out     = addr_q;
   assign reg_load_complete_out = complete_q;
   assign load_error_out        = error_q;

endmodule

// File: tb/tb_mpu_load.sv
// Directed bench for mpu_load: row-major load sequences, source bubbles,
// rejected requests, mid-load reset and back-to-back requests.
module tb_mpu_load;

   logic        clk = 1'b0;
   logic        rst;
   logic        loadReq;
   logic [2:0]  addrIn;
   logic [2:0]  mSize;
   logic [2:0]  nSize;
   logic        memValid;
   logic [63:0] memElement;
   logic        memReady;
   logic        regEn;
   logic [63:0] regElement;
   logic [2:0]  regILoc;
   logic [2:0]  regJLoc;
   logic [2:0]  regMSize;
   logic [2:0]  regNSize;
   logic [2:0]  regAddr;
   logic        regComplete;
   logic        loadBusy;
   logic        loadError;

   int testsRun    = 0;
   int testsFailed = 0;

   mpu_load #(.FP(64), .MBITS(2), .NBITS(2), .MATRIX_REG_SIZE(3)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .load_req_in           (loadReq),
      .load_addr_in          (addrIn),
      .mem_m_load_size_in    (mSize),
      .mem_n_load_size_in    (nSize),
      .mem_load_en_in        (memValid),
      .mem_load_element_in   (memElement),
      .mem_load_ready_out    (memReady),
      .reg_load_en_out       (regEn),
      .reg_element_out       (regElement),
      .reg_i_load_loc_out    (regILoc),
      .reg_j_load_loc_out    (regJLoc),
      .reg_m_load_size_out   (regMSize),
      .reg_n_load_size_out   (regNSize),
      .reg_load_addr_out     (regAddr),
      .reg_load_complete_out (regComplete),
      .load_busy_out         (loadBusy),
      .load_error_out        (loadError)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge so outputs are stable.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " ready"},    64'(memReady), 64'd0);
      checkOutput({tag, " en"},       64'(regEn), 64'd0);
      checkOutput({tag, " element"},  regElement, 64'd0);
      checkOutput({tag, " i"},        64'(regILoc), 64'd0);
      checkOutput({tag, " j"},        64'(regJLoc), 64'd0);
      checkOutput({tag, " msize"},    64'(regMSize), 64'd0);
      checkOutput({tag, " nsize"},    64'(regNSize), 64'd0);
      checkOutput({tag, " addr"},     64'(regAddr), 64'd0);
      checkOutput({tag, " complete"}, 64'(regComplete), 64'd0);
      checkOutput({tag, " busy"},     64'(loadBusy), 64'd0);
      checkOutput({tag, " error"},    64'(loadError), 64'd0);
   endtask

   // Issue a request, then stream m*n elements; gaps inserts an idle cycle before
   // each element, pulseAt injects a stray request, abortAfter resets mid-load.
   task automatic applyStimulus(input int m, input int n, input int a, input bit gaps,
                                input int base, input int pulseAt, input int abortAfter);
      logic [63:0] expElem;
      loadReq = 1'b1;
      mSize   = 3'(m);
      nSize   = 3'(n);
      addrIn  = 3'(a);
      tick();
      loadReq = 1'b0;
      checkOutput("accept en",    64'(regEn), 64'd0);
      checkOutput("accept ready", 64'(memReady), 64'd1);
      checkOutput("accept busy",  64'(loadBusy), 64'd1);
      checkOutput("accept addr",  64'(regAddr), 64'(a));
      checkOutput("accept msize", 64'(regMSize), 64'(m));
      checkOutput("accept nsize", 64'(regNSize), 64'(n));
      for (int idx = 0; idx < m * n; idx++) begin
         if (idx == abortAfter) begin
            rst      = 1'b1;
            memValid = 1'b1;
            tick();
            checkAllZero("abort");
            rst = 1'b0;
            return;
         end
         if (gaps) begin
            memValid = 1'b0;
            tick();
            checkOutput("gap ready", 64'(memReady), 64'd1);
            checkOutput("gap en",    64'(regEn), 64'd0);
         end
         expElem    = $realtobits(real'(base + idx + 1));
         memValid   = 1'b1;
         memElement = expElem;
         if (idx == pulseAt) begin
            loadReq = 1'b1;
            mSize   = 3'd1;
            nSize   = 3'd1;
            addrIn  = 3'd0;
         end
         checkOutput("pre ready", 64'(memReady), 64'd1);
         tick();
         loadReq = 1'b0;
         checkOutput("write en",       64'(regEn), 64'd1);
         checkOutput("write element",  regElement, expElem);
         checkOutput("write i",        64'(regILoc), 64'(idx / n));
         checkOutput("write j",        64'(regJLoc), 64'(idx % n));
         checkOutput("write complete", 64'(regComplete), 64'(idx == m * n - 1));
         if (idx == pulseAt) begin
            checkOutput("stray req error", 64'(loadError), 64'd0);
            checkOutput("stray req msize", 64'(regMSize), 64'(m));
         end
      end
      checkOutput("done ready", 64'(memReady), 64'd0);
      checkOutput("done busy",  64'(loadBusy), 64'd0);
      memElement = 64'hDEAD_BEEF_0000_0000;
   endtask

   initial begin
      rst        = 1'b1;
      loadReq    = 1'b0;
      addrIn     = '0;
      mSize      = '0;
      nSize      = '0;
      memValid   = 1'b0;
      memElement = '0;
      tick();
      tick();
      checkAllZero("reset");
      rst = 1'b0;
      tick();

      applyStimulus(2, 3, 5, 1'b0, 0, -1, -1);
      applyStimulus(2, 3, 2, 1'b1, 10, -1, -1);
      applyStimulus(1, 1, 1, 1'b1, 20, -1, -1);
      tick();
      checkOutput("post 1x1 en",    64'(regEn), 64'd0);
      checkOutput("post 1x1 ready", 64'(memReady), 64'd0);

      loadReq  = 1'b1;
      mSize    = 3'd0;
      nSize    = 3'd4;
      addrIn   = 3'd6;
      memValid = 1'b1;
      tick();
      loadReq = 1'b0;
      checkOutput("zero-m error", 64'(loadError), 64'd1);
      checkOutput("zero-m ready", 64'(memReady), 64'd0);
      checkOutput("zero-m en",    64'(regEn), 64'd0);
      checkOutput("zero-m addr",  64'(regAddr), 64'd1);
      tick();
      checkOutput("zero-m error end", 64'(loadError), 64'd0);
      checkOutput("zero-m ready end", 64'(memReady), 64'd0);
      checkOutput("zero-m en end",    64'(regEn), 64'd0);

      applyStimulus(1, 1, 3, 1'b0, 30, -1, -1);
      memValid = 1'b0;
      tick();
      applyStimulus(3, 3, 4, 1'b0, 40, -1, 4);
      applyStimulus(2, 2, 7, 1'b0, 50, -1, -1);
      applyStimulus(7, 7, 6, 1'b0, 60, 20, -1);
      applyStimulus(1, 1, 2, 1'b0, 200, -1, -1);
      tick();
      checkOutput("final en",       64'(regEn), 64'd0);
      checkOutput("final complete", 64'(regComplete), 64'd0);
      checkOutput("final ready",    64'(memReady), 64'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
